// File: rtl/linear_sensor_line_sequencer.sv
// Linear CCD line sequencer: drives the shift gate and phase clock, strobes the
// ADC, and replays each line of samples as a framed pixel stream.
module linear_sensor_line_sequencer #(
  parameter int PIXEL_CLOCK_DIVIDER = 50,
  parameter int PIXELS_PER_LINE     = 1024,
  parameter int DUMMY_PIXELS        = 32,
  parameter int SH_PULSE_WIDTH      = 100,
  parameter int LINE_GAP_PIXELS     = 16,
  parameter int LINE_COUNT_WIDTH    = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [7:0]                  adc_data,
  output logic                        sh,
  output logic                        phi,
  output logic                        adc_convert,
  output logic [7:0]                  data,
  output logic                        pixel_clock,
  output logic                        start,
  output logic                        stop,
  output logic                        clear,
  output logic [LINE_COUNT_WIDTH-1:0] line_count
);

  localparam int DIV_W = $clog2(PIXEL_CLOCK_DIVIDER);
  localparam int PER_W = $clog2(PIXELS_PER_LINE + DUMMY_PIXELS + LINE_GAP_PIXELS + 2);
  localparam int SH_W  = $clog2(SH_PULSE_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST        = DIV_W'(PIXEL_CLOCK_DIVIDER - 1);
  localparam logic [DIV_W-1:0] DIV_HALF        = DIV_W'(PIXEL_CLOCK_DIVIDER / 2);
  localparam logic [PER_W-1:0] PER_DUMMY_LAST  = PER_W'(DUMMY_PIXELS - 1);
  localparam logic [PER_W-1:0] PER_ACTIVE_LAST = PER_W'(PIXELS_PER_LINE);
  localparam logic [PER_W-1:0] PER_GAP_LAST    = PER_W'(LINE_GAP_PIXELS - 1);
  localparam logic [SH_W-1:0]  SH_LAST         = SH_W'(SH_PULSE_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, DUMMY, ACTIVE, GAP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [PER_W-1:0] per_cnt, per_nxt;
  logic [SH_W-1:0]  sh_cnt, sh_nxt;
  logic [7:0]       sample;
  logic             period_end;
  logic             sh_d, phi_d, adc_d, pix_d, clear_d, start_d, stop_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      div_cnt <= '0;
      per_cnt <= '0;
      sh_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      per_cnt <= per_nxt;
      sh_cnt  <= sh_nxt;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // exactly with the state they describe.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    per_nxt    = per_cnt;
    sh_nxt     = sh_cnt;
    period_end = (div_cnt == DIV_LAST);
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SHIFT;
          sh_nxt    = '0;
        end
      end
      SHIFT: begin
        if (sh_cnt == SH_LAST) begin
          state_nxt = DUMMY;
          per_nxt   = '0;
        end else begin
          sh_nxt = sh_cnt + SH_W'(1);
        end
      end
      default: begin
        div_nxt = period_end ? '0 : div_cnt + DIV_W'(1);
        if (period_end) begin
          per_nxt = per_cnt + PER_W'(1);
          case (state)
            DUMMY: if (per_cnt == PER_DUMMY_LAST) begin
              state_nxt = ACTIVE;
              per_nxt   = '0;
            end
            ACTIVE: if (per_cnt == PER_ACTIVE_LAST) begin
              state_nxt = GAP;
              per_nxt   = '0;
            end
            GAP: if (per_cnt == PER_GAP_LAST) begin
              state_nxt = enable ? SHIFT : IDLE;
              per_nxt   = '0;
              sh_nxt    = '0;
            end
            default: ;
          endcase
        end
      end
    endcase

    sh_d    = (state_nxt == SHIFT);
    clear_d = (state_nxt == IDLE);
    phi_d   = (state_nxt == DUMMY || state_nxt == ACTIVE || state_nxt == GAP) && (div_nxt < DIV_HALF);
    adc_d   = (state_nxt == DUMMY || state_nxt == ACTIVE) && (div_nxt == DIV_HALF);
    pix_d   = (state_nxt == ACTIVE) && (per_nxt != '0) && (div_nxt >= DIV_HALF);
    start_d = (state == DUMMY) && (state_nxt == ACTIVE);
    stop_d  = (state == ACTIVE) && (state_nxt == GAP);
  end

  // Period N only flushes the previous sample; nothing is latched in it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sample      <= '0;
      data        <= '0;
      sh          <= 1'b0;
      phi         <= 1'b0;
      adc_convert <= 1'b0;
      pixel_clock <= 1'b0;
      start       <= 1'b0;
      stop        <= 1'b0;
      clear       <= 1'b1;
      line_count  <= '0;
    end else begin
      if (state == ACTIVE && period_end && per_cnt != PER_ACTIVE_LAST)
        sample <= adc_data;
      if (state == ACTIVE && div_cnt == '0 && per_cnt != '0)
        data <= sample;
      sh          <= sh_d;
      phi         <= phi_d;
      adc_convert <= adc_d;
      pixel_clock <= pix_d;
      start       <= start_d;
      stop        <= stop_d;
      clear       <= clear_d;
      if (stop_d)
        line_count <= line_count + LINE_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_linear_sensor_line_sequencer.sv
// Bench for linear_sensor_line_sequencer: an ADC model feeds pixel indices and
// queues the expected stream; line scenarios are driven from a vector table.
module tb_linear_sensor_line_sequencer;

  localparam int DIV   = 8;
  localparam int N     = 16;
  localparam int DUMMY = 2;
  localparam int SH    = 5;
  localparam int GAP   = 2;
  localparam int LCW   = 4;
  // SH + (DUMMY + N + 1 + GAP) * DIV
  localparam int LINE_PERIOD = 173;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           enable = 1'b0;
  logic [7:0]     adc_data = 8'd0;
  logic           sh, phi, adc_convert, pixel_clock, start, stop, clear;
  logic [7:0]     data;
  logic [LCW-1:0] line_count;

  linear_sensor_line_sequencer #(
    .PIXEL_CLOCK_DIVIDER(DIV),
    .PIXELS_PER_LINE(N),
    .DUMMY_PIXELS(DUMMY),
    .SH_PULSE_WIDTH(SH),
    .LINE_GAP_PIXELS(GAP),
    .LINE_COUNT_WIDTH(LCW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .adc_data(adc_data),
    .sh(sh),
    .phi(phi),
    .adc_convert(adc_convert),
    .data(data),
    .pixel_clock(pixel_clock),
    .start(start),
    .stop(stop),
    .clear(clear),
    .line_count(line_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    string name;
    int    lines;
    int    drop_pixel;
    int    exp_pixels;
    int    exp_converts;
    int    exp_sh_cycles;
    int    exp_line_count;
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;

  // Monitor-owned state
  int         cycle = 0, conv_idx = 0, last_start = -1;
  int         starts = 0, stops = 0, pix_rises = 0, converts = 0;
  int         sh_cycles = 0, sh_rises = 0, phi_in_sh = 0;
  int         intervals = 0, bad_intervals = 0;
  int         pix_errors = 0, unstable = 0, overlap = 0, leftover = 0;
  logic       prev_pc = 1'b0, prev_sh = 1'b0;
  logic [7:0] held = 8'd0, exp_val;
  logic [7:0] exp_q[$];
  int         lc_log[$];

  // Snapshots taken by the main sequence
  int b_starts, b_stops, b_pix, b_conv, b_shc, b_shr, b_phi, b_int, b_bad;
  int b_perr, b_unst, b_ovl, b_left, b_drop;

  // ADC model and scoreboard: each convert returns its index within the line
  initial begin : monitor
    forever begin
      @(negedge aclk);
      cycle++;
      if (!aresetn) begin
        exp_q.delete();
        conv_idx   = 0;
        prev_pc    = 1'b0;
        prev_sh    = 1'b0;
        last_start = -1;
      end else begin
        if (sh) begin
          sh_cycles++;
          conv_idx = 0;
          if (phi) phi_in_sh++;
        end
        if (sh && !prev_sh) sh_rises++;
        if (adc_convert) begin
          adc_data = 8'(conv_idx);
          if (conv_idx >= DUMMY && conv_idx < DUMMY + N) exp_q.push_back(8'(conv_idx));
          conv_idx++;
          converts++;
        end
        if (pixel_clock && !prev_pc) begin
          pix_rises++;
          if (exp_q.size() == 0) pix_errors++;
          else begin
            exp_val = exp_q.pop_front();
            if (data !== exp_val) pix_errors++;
          end
          held = data;
        end
        if (!pixel_clock && prev_pc && data !== held) unstable++;
        if (start && stop) overlap++;
        if (start) begin
          starts++;
          if (last_start >= 0) begin
            intervals++;
            if (cycle - last_start != LINE_PERIOD) bad_intervals++;
          end
          last_start = cycle;
        end
        if (stop) begin
          stops++;
          if (exp_q.size() != 0) leftover++;
          lc_log.push_back(int'(line_count));
        end
        if (clear) last_start = -1;
        prev_pc = pixel_clock;
        prev_sh = sh;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: time %0t reached, limit 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic waitStarts(input int target, input int budget);
    int n = 0;
    while (starts < target && n < budget) begin tick(); n++; end
    if (starts < target) compare("timeout waiting for start", starts, target);
  endtask

  task automatic waitStops(input int target, input int budget);
    int n = 0;
    while (stops < target && n < budget) begin tick(); n++; end
    if (stops < target) compare("timeout waiting for stop", stops, target);
  endtask

  task automatic waitPixels(input int target, input int budget);
    int n = 0;
    while (pix_rises < target && n < budget) begin tick(); n++; end
    if (pix_rises < target) compare("timeout waiting for pixels", pix_rises, target);
  endtask

  task automatic takeSnapshot();
    b_starts = starts; b_stops = stops; b_pix = pix_rises; b_conv = converts;
    b_shc = sh_cycles; b_shr = sh_rises; b_phi = phi_in_sh; b_int = intervals;
    b_bad = bad_intervals; b_perr = pix_errors; b_unst = unstable;
    b_ovl = overlap; b_left = leftover;
  endtask

  task automatic applyReset();
    aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    takeSnapshot();
    enable = 1'b1;
    waitStarts(b_starts + v.lines, v.lines * LINE_PERIOD + 50);
    waitPixels(b_pix + (v.lines - 1) * N + v.drop_pixel, 2 * LINE_PERIOD);
    b_drop = pix_rises;
    enable = 1'b0;
    waitStops(b_stops + v.lines, 2 * LINE_PERIOD);
    repeat (60) tick();
  endtask

  task automatic checkOutput(input vec_t v);
    compare({v.name, " starts"}, starts - b_starts, v.lines);
    compare({v.name, " stops"}, stops - b_stops, v.lines);
    compare({v.name, " pixel rises"}, pix_rises - b_pix, v.exp_pixels);
    compare({v.name, " pixels after drop"}, pix_rises - b_drop, N - v.drop_pixel);
    compare({v.name, " pixel data errors"}, pix_errors - b_perr, 0);
    compare({v.name, " data unstable"}, unstable - b_unst, 0);
    compare({v.name, " adc converts"}, converts - b_conv, v.exp_converts);
    compare({v.name, " sh cycles"}, sh_cycles - b_shc, v.exp_sh_cycles);
    compare({v.name, " sh rises"}, sh_rises - b_shr, v.lines);
    compare({v.name, " phi during sh"}, phi_in_sh - b_phi, 0);
    compare({v.name, " start intervals"}, intervals - b_int, v.lines - 1);
    compare({v.name, " bad start intervals"}, bad_intervals - b_bad, 0);
    compare({v.name, " start with stop"}, overlap - b_ovl, 0);
    compare({v.name, " pixels left at stop"}, leftover - b_left, 0);
    compare({v.name, " clear idle"}, clear, 1);
    compare({v.name, " line_count"}, line_count, v.exp_line_count);
  endtask

  initial begin : main
    vec_t vecs[4];
    vec_t restart;
    int   base_log;

    vecs[0] = '{"single line",          1,  0, 16, 19,  5, 1};
    vecs[1] = '{"three lines",          3, 16, 48, 57, 15, 4};
    vecs[2] = '{"drop at pixel 5",      1,  5, 16, 19,  5, 5};
    vecs[3] = '{"two lines drop at 10", 2, 10, 32, 38, 10, 7};
    restart = '{"restart after abort",  1,  0, 16, 19,  5, 1};

    // Reset values, then an idle stretch with enable low
    aresetn = 1'b0;
    enable  = 1'b0;
    repeat (3) tick();
    compare("reset clear", clear, 1);
    compare("reset sh", sh, 0);
    compare("reset phi", phi, 0);
    compare("reset adc_convert", adc_convert, 0);
    compare("reset data", data, 0);
    compare("reset pixel_clock", pixel_clock, 0);
    compare("reset start", start, 0);
    compare("reset stop", stop, 0);
    compare("reset line_count", line_count, 0);
    aresetn = 1'b1;
    repeat (100) tick();
    compare("idle clear", clear, 1);
    compare("idle sh rises", sh_rises, 0);
    compare("idle phi", phi, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Reset asserted mid-ACTIVE must clear outputs without waiting for a clock
    takeSnapshot();
    enable = 1'b1;
    waitStarts(b_starts + 1, LINE_PERIOD);
    waitPixels(b_pix + 5, LINE_PERIOD);
    #2 aresetn = 1'b0;
    #1;
    compare("abort clear", clear, 1);
    compare("abort sh", sh, 0);
    compare("abort phi", phi, 0);
    compare("abort pixel_clock", pixel_clock, 0);
    compare("abort adc_convert", adc_convert, 0);
    compare("abort data", data, 0);
    compare("abort line_count", line_count, 0);
    enable = 1'b0;
    repeat (20) tick();
    compare("abort no stop", stops - b_stops, 0);
    aresetn = 1'b1;
    tick();
    applyStimulus(restart);
    checkOutput(restart);

    // 17 back-to-back lines wrap the 4-bit line counter
    applyReset();
    takeSnapshot();
    base_log = lc_log.size();
    enable = 1'b1;
    waitStarts(b_starts + 17, 18 * LINE_PERIOD);
    enable = 1'b0;
    waitStops(b_stops + 17, 2 * LINE_PERIOD);
    repeat (30) tick();
    compare("wrap stops logged", lc_log.size() - base_log, 17);
    for (int k = 0; k < 17; k++) begin
      if (base_log + k < lc_log.size())
        compare($sformatf("line_count after stop %0d", k + 1), lc_log[base_log + k], (k + 1) % 16);
    end
    compare("wrap start intervals", intervals - b_int, 16);
    compare("wrap bad start intervals", bad_intervals - b_bad, 0);
    compare("wrap pixel data errors", pix_errors - b_perr, 0);
    compare("wrap adc converts", converts - b_conv, 17 * 19);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
